// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter for the shared fifo write port.
// A grant is held from a packet's first beat until its last beat (or a
// forced release at P_MAX_BEATS), so packets never interleave in the fifo.
module fifo_wr_arbiter #(
    parameter int unsigned P_NUM       = 4,
    parameter int unsigned P_WIDTH     = 8,
    parameter int unsigned P_MAX_BEATS = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [P_NUM*P_WIDTH-1:0]   req_data,
    input  logic [P_NUM-1:0]           req_vld,
    input  logic [P_NUM-1:0]           req_last,
    output logic [P_NUM-1:0]           req_rdy,
    output logic [P_WIDTH-1:0]         fifo_wr_data,
    output logic                       fifo_wr_vld,
    input  logic                       fifo_wr_rdy,
    output logic [$clog2(P_NUM)-1:0]   grant_id,
    output logic                       busy,
    output logic                       pkt_trunc
);

    localparam int unsigned GW = $clog2(P_NUM);
    localparam int unsigned CW = $clog2(P_MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            pkt_trunc_q, pkt_trunc_d;

    logic            found;
    logic [GW-1:0]   winner;
    logic            g_vld;
    logic            g_last;
    logic            accept;

    // Rotating-priority search: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = 0;
        for (int unsigned k = 0; k < P_NUM; k++) begin
            idx = k + int'(rr_ptr_q);
            if (idx >= P_NUM) begin
                idx = idx - P_NUM;
            end
            if (!found && req_vld[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    // Combinational routing of the granted requester onto the fifo write port.
    always_comb begin
        fifo_wr_data = '0;
        req_rdy      = '0;
        for (int unsigned i = 0; i < P_NUM; i++) begin
            if (grant_id_q == GW'(i)) begin
                fifo_wr_data = req_data[i*P_WIDTH +: P_WIDTH];
                req_rdy[i]   = (state_q == BUSY) && fifo_wr_rdy;
            end
        end
    end

    assign g_vld       = req_vld[grant_id_q];
    assign g_last      = req_last[grant_id_q];
    assign busy        = (state_q == BUSY);
    assign fifo_wr_vld = busy && g_vld;
    assign accept      = busy && g_vld && fifo_wr_rdy;
    assign grant_id    = grant_id_q;
    assign pkt_trunc   = pkt_trunc_q;

    // Next-state logic: arbitrate in IDLE, count accepted beats and release in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_trunc_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (g_last || (beat_cnt_q == CW'(P_MAX_BEATS - 1))) begin
                        state_d     = IDLE;
                        rr_ptr_d    = (grant_id_q == GW'(P_NUM - 1)) ? '0 : grant_id_q + GW'(1);
                        pkt_trunc_d = !g_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            pkt_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_trunc_q <= pkt_trunc_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a packet-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*W-1:0]       req_data;
    logic [N-1:0]         req_vld;
    logic [N-1:0]         req_last;
    logic [N-1:0]         req_rdy;
    logic [W-1:0]         fifo_wr_data;
    logic                 fifo_wr_vld;
    logic                 fifo_wr_rdy;
    logic [$clog2(N)-1:0] grant_id;
    logic                 busy;
    logic                 pkt_trunc;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .P_NUM      (N),
        .P_WIDTH    (W),
        .P_MAX_BEATS(MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data    (req_data),
        .req_vld     (req_vld),
        .req_last    (req_last),
        .req_rdy     (req_rdy),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_vld (fifo_wr_vld),
        .fifo_wr_rdy (fifo_wr_rdy),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_trunc   (pkt_trunc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: packet owner, rotation pointer, beats of current packet.
    int m_busy, m_g, m_ptr, m_cnt, m_trunc;
    int order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_g     = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_trunc = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_rdy;
        e_rdy = '0;
        if (m_busy != 0 && fifo_wr_rdy) e_rdy[m_g] = 1'b1;
        check("busy",      32'(busy),        m_busy);
        check("grant_id",  32'(grant_id),    m_g);
        check("pkt_trunc", 32'(pkt_trunc),   m_trunc);
        check("wr_vld",    32'(fifo_wr_vld), (m_busy != 0) ? 32'(req_vld[m_g]) : 0);
        check("req_rdy",   32'(req_rdy),     32'(e_rdy));
        if (m_busy != 0 && req_vld[m_g])
            check("wr_data", 32'(fifo_wr_data), 32'(req_data[m_g*W +: W]));
    endtask

    task automatic model_edge();
        m_trunc = 0;
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req_vld[idx]) begin
                    m_g    = idx;
                    m_busy = 1;
                    m_cnt  = 0;
                    break;
                end
            end
        end else if (req_vld[m_g] && fifo_wr_rdy) begin
            m_cnt++;
            if (req_last[m_g] || m_cnt == MB) begin
                m_trunc = req_last[m_g] ? 0 : 1;
                m_busy  = 0;
                m_ptr   = (m_g + 1) % N;
            end
        end
    endtask

    // One clock: drive at negedge, check settled outputs, advance model at posedge.
    task automatic step(input logic [N-1:0] vld, input logic [N-1:0] last, input logic rdy);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_vld     = vld;
        req_last    = last;
        fifo_wr_rdy = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Asynchronous reset applied between clock edges, released at a negedge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_order[5];
        rst_n       = 1'b0;
        req_data    = '0;
        req_vld     = '0;
        req_last    = '0;
        fifo_wr_rdy = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // All requesting single-beat packets: strict rotation 0,1,2,3,0.
        for (int s = 0; s < 10; s++) begin
            step(4'b1111, 4'b1111, 1'b1);
            if (busy) order.push_back(int'(grant_id));
        end
        exp_order = '{0, 1, 2, 3, 0};
        check("order_len", 32'(order.size() >= 5), 1);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);

        // 3-beat packet from req0 while req2 waits.
        do_reset();
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0001, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);

        // Back-pressure for 5 cycles mid-packet on req1.
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        for (int s = 0; s < 5; s++) step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0010, 1'b1);

        // Truncation: req1 streams 6 beats without last.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1);
        for (int s = 0; s < 6; s++) step(4'b0010, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Pointer wrap after req3, then bubble mid-packet on req0.
        do_reset();
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        check("wrap_grant", 32'(grant_id), 0);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0001, 4'b0001, 1'b1);

        // Reset while streaming, then lowest pending index wins from rr_ptr=0.
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b1);
        req_vld = 4'b1111;
        do_reset();
        step(4'b0110, 4'b0000, 1'b1);
        check("post_rst_grant", 32'(grant_id), 1);

        // Random traffic.
        for (int s = 0; s < 3000; s++) begin
            logic [N-1:0] v, l;
            v = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 2) == 0);
            step(v, l, $urandom_range(0, 3) != 0);
            if (s == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
